// File: rtl/nmr_param_bank.sv
//------------------------------------------------------------------------------
// nmr_param_bank : double-buffered NMR sequencer parameter bank (Avalon-MM slave)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nmr_param_bank #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 3,
  parameter int RESET_VAL = 9732
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  input  logic                     sync_evt,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic                     commit_pulse
);

  localparam logic [DATA_W-1:0] RST_WORD  = DATA_W'(RESET_VAL);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] RDBK_ADDR = ADDR_W'(NUM_CH + 1);

  logic [DATA_W-1:0] shadow [NUM_CH];
  logic [DATA_W-1:0] active [NUM_CH];
  logic              armed;
  logic              dirty;
  logic [7:0]        commit_cnt;
  logic [3:0]        sel;

  logic wr, shadow_wr, ctrl_wr, rdbk_wr, commit;

  always_comb begin
    wr        = chipselect & ~write_n;
    shadow_wr = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      if (address == ADDR_W'(k)) shadow_wr = wr;
    ctrl_wr   = wr && (address == CTRL_ADDR);
    rdbk_wr   = wr && (address == RDBK_ADDR);
    // Immediate and armed triggers in one cycle collapse into a single commit.
    commit    = (ctrl_wr & writedata[0]) | (armed & sync_evt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shadow[k] <= RST_WORD;
        active[k] <= RST_WORD;
      end
      armed        <= 1'b0;
      dirty        <= 1'b0;
      commit_cnt   <= 8'd0;
      sel          <= 4'd0;
      commit_pulse <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr && address == ADDR_W'(k)) shadow[k] <= writedata[DATA_W-1:0];
        if (commit)                      active[k] <= shadow[k];
      end

      // CANCEL beats ARM; ARM beats the self-clear of a commit (re-arm).
      if (ctrl_wr && writedata[2])      armed <= 1'b0;
      else if (ctrl_wr && writedata[1]) armed <= 1'b1;
      else if (commit)                  armed <= 1'b0;

      if (shadow_wr)   dirty <= 1'b1;
      else if (commit) dirty <= 1'b0;

      if (commit)  commit_cnt <= commit_cnt + 8'd1;
      if (rdbk_wr) sel        <= writedata[3:0];
      commit_pulse <= commit;
    end
  end

  always_comb begin
    readdata = 32'd0;
    for (int k = 0; k < NUM_CH; k++)
      if (address == ADDR_W'(k)) readdata = 32'(shadow[k]);
    if (address == CTRL_ADDR)
      readdata = {16'd0, commit_cnt, 6'd0, dirty, armed};
    if (address == RDBK_ADDR)
      for (int k = 0; k < NUM_CH; k++)
        if (sel == 4'(k)) readdata = 32'(active[k]);
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign out_port[g*DATA_W +: DATA_W] = active[g];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_nmr_param_bank.sv
//------------------------------------------------------------------------------
// tb_nmr_param_bank : directed self-checking bench for nmr_param_bank
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_nmr_param_bank;

  localparam int RV = 32'h2604;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic         sync_evt = 1'b0;
  logic [127:0] out_port;
  logic         commit_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  nmr_param_bank dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .sync_evt     (sync_evt),
    .out_port     (out_port),
    .commit_pulse (commit_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic avl_wr(input logic [2:0] a, input logic [31:0] d, input logic s = 1'b0);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0; sync_evt = s;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; sync_evt = 1'b0;
  endtask

  task automatic avl_rd(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
  endtask

  task automatic sync_pulse();
    @(negedge clk); sync_evt = 1'b1;
    @(negedge clk); sync_evt = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    // 1. reset defaults
    #12 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      avl_rd(3'(k), rd);          check($sformatf("rst_shadow%0d", k), rd, RV);
      check($sformatf("rst_out%0d", k), out_port[k*32 +: 32], RV);
      avl_wr(3'd5, 32'(k));
      avl_rd(3'd5, rd);           check($sformatf("rst_rdbk%0d", k), rd, RV);
    end
    avl_rd(3'd4, rd);             check("rst_status", rd, 32'h0);
    check("rst_pulse", 32'(commit_pulse), 32'h0);

    // 2. shadow writes then immediate commit
    avl_wr(3'd0, 32'h11); avl_wr(3'd1, 32'h22); avl_wr(3'd2, 32'h33); avl_wr(3'd3, 32'h44);
    check("pre_commit_out0", out_port[31:0], RV);
    avl_rd(3'd4, rd);             check("dirty_set", rd, 32'h2);
    avl_wr(3'd4, 32'h1);
    check("now_pulse", 32'(commit_pulse), 32'h1);
    check("now_out0", out_port[31:0],   32'h11);
    check("now_out1", out_port[63:32],  32'h22);
    check("now_out2", out_port[95:64],  32'h33);
    check("now_out3", out_port[127:96], 32'h44);
    avl_rd(3'd4, rd);             check("now_status", rd, 32'h100);
    @(negedge clk);
    check("now_pulse_end", 32'(commit_pulse), 32'h0);

    // 3. armed commit; sync with the ARM write does not commit
    avl_wr(3'd1, 32'hABCD);
    avl_wr(3'd4, 32'h2, 1'b1);
    check("arm_sync_nocommit", out_port[63:32], 32'h22);
    avl_rd(3'd4, rd);             check("armed_status", rd, 32'h103);
    repeat (4) @(negedge clk);
    sync_pulse();
    check("armed_out1", out_port[63:32], 32'hABCD);
    check("armed_pulse", 32'(commit_pulse), 32'h1);
    avl_rd(3'd4, rd);             check("armed_done_status", rd, 32'h200);
    sync_pulse();
    check("unarmed_sync_out1", out_port[63:32], 32'hABCD);
    check("unarmed_sync_pulse", 32'(commit_pulse), 32'h0);
    avl_rd(3'd4, rd);             check("unarmed_sync_status", rd, 32'h200);

    // 4. shadow write racing an armed commit
    avl_wr(3'd4, 32'h2);
    avl_rd(3'd4, rd);             check("rearm_status", rd, 32'h201);
    avl_wr(3'd2, 32'h99, 1'b1);
    check("race_out2", out_port[95:64], 32'h33);
    avl_rd(3'd2, rd);             check("race_shadow2", rd, 32'h99);
    avl_rd(3'd4, rd);             check("race_status", rd, 32'h302);

    // 5. control priority and counter wrap
    avl_wr(3'd4, 32'h2);
    avl_wr(3'd4, 32'h6);
    avl_rd(3'd4, rd);             check("arm_cancel", rd, 32'h302);
    avl_wr(3'd4, 32'h3);
    check("now_arm_out2", out_port[95:64], 32'h99);
    avl_rd(3'd4, rd);             check("now_arm_status", rd, 32'h401);
    avl_wr(3'd4, 32'h4);
    avl_rd(3'd4, rd);             check("cancel_status", rd, 32'h400);
    @(negedge clk);
    address = 3'd4; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    repeat (251) @(negedge clk);
    check("burst_pulse", 32'(commit_pulse), 32'h1);
    chipselect = 1'b0; write_n = 1'b1;
    avl_rd(3'd4, rd);             check("cnt_255", rd, 32'hFF00);
    @(negedge clk);
    check("burst_pulse_end", 32'(commit_pulse), 32'h0);
    avl_wr(3'd4, 32'h1);
    avl_rd(3'd4, rd);             check("cnt_wrap", rd, 32'h0);
    avl_wr(3'd4, 32'h2);
    avl_wr(3'd4, 32'h1, 1'b1);
    check("dual_trig_pulse", 32'(commit_pulse), 32'h1);
    avl_rd(3'd4, rd);             check("dual_trig_status", rd, 32'h100);
    @(negedge clk);
    check("dual_trig_pulse_end", 32'(commit_pulse), 32'h0);

    // 6. readback select, unmapped address, async reset while armed
    avl_wr(3'd5, 32'h2);
    avl_rd(3'd5, rd);             check("rdbk_sel2", rd, 32'h99);
    avl_wr(3'd5, 32'h7);
    avl_rd(3'd5, rd);             check("rdbk_sel7", rd, 32'h0);
    avl_wr(3'd7, 32'hDEAD);
    avl_rd(3'd7, rd);             check("unmapped_rd", rd, 32'h0);
    avl_rd(3'd0, rd);             check("unmapped_wr_shadow0", rd, 32'h11);
    avl_rd(3'd4, rd);             check("unmapped_wr_status", rd, 32'h100);
    avl_wr(3'd4, 32'h3);
    check("pre_reset_pulse", 32'(commit_pulse), 32'h1);
    avl_rd(3'd4, rd);             check("pre_reset_status", rd, 32'h201);
    reset = 1'b1;
    #1;
    check("areset_pulse", 32'(commit_pulse), 32'h0);
    avl_rd(3'd4, rd);             check("areset_status", rd, 32'h0);
    for (int k = 0; k < 4; k++)
      check($sformatf("areset_out%0d", k), out_port[k*32 +: 32], RV);
    avl_rd(3'd1, rd);             check("areset_shadow1", rd, RV);
    avl_rd(3'd5, rd);             check("areset_rdbk", rd, RV);
    @(negedge clk);
    reset = 1'b0;
    chipselect = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
